// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// predictor state encodings and the IF/ID payload layout.
package if_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_SRC_W = 3;
  localparam int unsigned BP_W     = 2;

  typedef enum logic [PC_SRC_W-1:0] {
    PC_SEQ      = 3'd0,
    PC_PFC      = 3'd1,
    PC_ROLLBACK = 3'd2,
    PC_EXC      = 3'd3
  } pc_src_e;

  typedef enum logic [BP_W-1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_branch_predictor.sv
// Two-bit saturating branch predictor; trained only by resolved branches
// from execute, independent of any pipeline stall or flush.
module branch_predictor_2bit
  import if_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic br_resolved,
  input  logic br_taken,
  output logic predict_taken
);

  bp_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= BP_WNT;
    else      state_q <= state_d;
  end

  // Saturating up/down count on each resolution.
  always_comb begin
    state_d = state_q;
    if (br_resolved) begin
      case (state_q)
        BP_SNT:  state_d = br_taken ? BP_WNT : BP_SNT;
        BP_WNT:  state_d = br_taken ? BP_WT  : BP_SNT;
        BP_WT:   state_d = br_taken ? BP_ST  : BP_WNT;
        BP_ST:   state_d = br_taken ? BP_ST  : BP_WT;
        default: state_d = BP_WNT;
      endcase
    end
  end

  assign predict_taken = state_q[BP_W-1];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register with next-PC selection, IF/ID pipeline
// register with hold/flush, and the branch direction predictor.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_03E8,
  parameter logic [XLEN-1:0] NOP_INST   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_SRC_W-1:0] pc_src,
  input  logic [XLEN-1:0]     pfc,
  input  logic [XLEN-1:0]     rollback_pc,
  input  logic                pc_write,
  input  logic                if_id_write,
  input  logic                if_id_flush,
  input  logic                ex_br_resolved,
  input  logic                ex_br_taken,
  output logic [XLEN-1:0]     im_addr,
  input  logic [XLEN-1:0]     im_data,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     if_id_pc,
  output logic [XLEN-1:0]     if_id_inst,
  output logic                if_id_valid,
  output logic                predict_taken
);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  // Rollback and exception redirects bypass the stall; seq/pfc honour it.
  always_comb begin
    pc_d = pc_q;
    case (pc_src_e'(pc_src))
      PC_ROLLBACK: pc_d = rollback_pc;
      PC_EXC:      pc_d = EXC_VECTOR;
      PC_PFC:      if (pc_write) pc_d = pfc;
      default:     if (pc_write) pc_d = pc_q + XLEN'(1);
    endcase
  end

  // Flush wins over hold and keeps the PC of the squashed slot.
  always_comb begin
    if_id_d = if_id_q;
    if (if_id_flush)      if_id_d = '{pc: pc_q, inst: NOP_INST, valid: 1'b0};
    else if (if_id_write) if_id_d = '{pc: pc_q, inst: im_data,  valid: 1'b1};
  end

  branch_predictor_2bit u_bp (
    .clk           (clk),
    .rst           (rst),
    .br_resolved   (ex_br_resolved),
    .br_taken      (ex_br_taken),
    .predict_taken (predict_taken)
  );

  assign im_addr     = pc_q;
  assign pc          = pc_q;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_inst  = if_id_q.inst;
  assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a behavioural reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  pc_src;
  logic [31:0] pfc, rollback_pc;
  logic        pc_write, if_id_write, if_id_flush;
  logic        ex_br_resolved, ex_br_taken;
  logic [31:0] im_addr, im_data, pc, if_id_pc, if_id_inst;
  logic        if_id_valid, predict_taken;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .pfc(pfc), .rollback_pc(rollback_pc),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .im_addr(im_addr), .im_data(im_data), .pc(pc), .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst), .if_id_valid(if_id_valid), .predict_taken(predict_taken)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  assign im_data = mem_word(im_addr);

  // Reference model: architectural state as plain values.
  logic [31:0] m_pc, m_ifpc, m_inst;
  logic        m_valid;
  int          m_ctr;
  logic        m_live = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_inst = 32'h0; m_valid = 1'b0; m_ctr = 1;
      m_live = 1'b1;
    end else begin
      if (if_id_flush) begin
        m_ifpc = m_pc; m_inst = 32'h0; m_valid = 1'b0;
      end else if (if_id_write) begin
        m_ifpc = m_pc; m_inst = mem_word(m_pc); m_valid = 1'b1;
      end
      if (ex_br_resolved)
        m_ctr = ex_br_taken ? ((m_ctr < 3) ? m_ctr + 1 : 3) : ((m_ctr > 0) ? m_ctr - 1 : 0);
      if (pc_src == 3'd2)      m_pc = rollback_pc;
      else if (pc_src == 3'd3) m_pc = 32'h3E8;
      else if (pc_write)       m_pc = (pc_src == 3'd1) ? pfc : m_pc + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checks++;
      if (im_addr !== m_pc || pc !== m_pc || if_id_pc !== m_ifpc || if_id_inst !== m_inst ||
          if_id_valid !== m_valid || predict_taken !== (m_ctr >= 2)) begin
        failures++;
        $display("FAIL model t=%0t got pc=%h ia=%h ifpc=%h inst=%h v=%b pt=%b want pc=%h ifpc=%h inst=%h v=%b pt=%b",
                 $time, pc, im_addr, if_id_pc, if_id_inst, if_id_valid, predict_taken,
                 m_pc, m_ifpc, m_inst, m_valid, (m_ctr >= 2));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] src, input logic pw, input logic iw, input logic fl);
    pc_src = src; pc_write = pw; if_id_write = iw; if_id_flush = fl;
  endtask

  initial begin
    rst = 1'b0; pfc = 32'h0; rollback_pc = 32'h0;
    ex_br_resolved = 1'b0; ex_br_taken = 1'b0;
    drive(3'd0, 1'b1, 1'b1, 1'b0);
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_inst", if_id_inst, 32'h0);
    chk("rst_pred_wnt", 32'(predict_taken), 32'h0);

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_pc", pc, 32'(i + 1));
      chk("seq_ifpc", if_id_pc, 32'(i));
      chk("seq_valid", 32'(if_id_valid), 32'h1);
      chk("seq_inst", if_id_inst, mem_word(32'(i)));
    end
    step(); step();
    chk("pc_at5", pc, 32'h5);

    pfc = 32'h40; drive(3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk("pfc_stall", pc, 32'h5);
    drive(3'd1, 1'b1, 1'b1, 1'b0);
    step(); chk("pfc_jump", pc, 32'h40);

    pfc = 32'h7; step(); chk("pc_at7", pc, 32'h7);
    rollback_pc = 32'h20; drive(3'd2, 1'b0, 1'b1, 1'b0);
    step(); chk("rollback", pc, 32'h20);
    drive(3'd3, 1'b0, 1'b1, 1'b0);
    step(); chk("exception", pc, 32'h3E8);

    drive(3'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk("flush_inst", if_id_inst, 32'h0);
    chk("flush_valid", 32'(if_id_valid), 32'h0);
    chk("flush_ifpc", if_id_pc, 32'h3E8);
    drive(3'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bubble_hold_valid", 32'(if_id_valid), 32'h0);
    chk("stall_pc", pc, 32'h3E8);

    // Predictor training: expected MSB after each resolution.
    ex_br_resolved = 1'b1; ex_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); chk("bp_taken", 32'(predict_taken), 32'h1); end
    ex_br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk("bp_not_taken", 32'(predict_taken), (i == 0) ? 32'h1 : 32'h0);
    end
    ex_br_resolved = 1'b0; ex_br_taken = 1'b1;
    step(); step(); chk("bp_ignored", 32'(predict_taken), 32'h0);

    pfc = 32'hFFFF_FFFF; drive(3'd1, 1'b1, 1'b1, 1'b0);
    step(); chk("pc_max", pc, 32'hFFFF_FFFF);
    drive(3'd0, 1'b1, 1'b1, 1'b0);
    step(); chk("pc_wrap", pc, 32'h0);
    drive(3'd5, 1'b1, 1'b1, 1'b0);
    step(); chk("src5_seq", pc, 32'h1);

    ex_br_resolved = 1'b1;
    step(); step(); chk("bp_up", 32'(predict_taken), 32'h1);
    drive(3'd0, 1'b0, 1'b0, 1'b1); rst = 1'b0;
    step();
    chk("rst_stall_pc", pc, 32'h0);
    chk("rst_stall_valid", 32'(if_id_valid), 32'h0);
    chk("rst_stall_pred", 32'(predict_taken), 32'h0);
    chk("rst_stall_ifpc", if_id_pc, 32'h0);
    ex_br_resolved = 1'b0; rst = 1'b1; drive(3'd0, 1'b1, 1'b1, 1'b0);
    step();
    chk("post_rst_ifpc", if_id_pc, 32'h0);
    chk("post_rst_inst", if_id_inst, mem_word(32'h0));
    chk("post_rst_pc", pc, 32'h1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
